// File: rtl/scr_trigger_pulse_gen_pkg.sv
// Shared state encodings and 50MHz-derived default timing for the SCR trigger pulse generator.
// The detector side imports the same timing constants so its check windows line up with the pulses.
package scr_trigger_pulse_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FWD_ON  = 3'd1,
    ST_FWD_OFF = 3'd2,
    ST_NEG_ON  = 3'd3,
    ST_NEG_OFF = 3'd4
  } state_e;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_PULSE_WIDTH  = 500;      // 10us
  localparam int unsigned DEF_HALF_PERIOD  = 500_000;  // 10ms
  localparam int unsigned DEF_CNT_W        = 20;
  localparam int unsigned PAIR_W           = 8;

  // A programmed pair count of zero means run until stopped.
  function automatic logic burst_complete(input logic [PAIR_W-1:0] pairs,
                                          input logic [PAIR_W-1:0] pairs_done);
    return (pairs != '0) && (pairs_done == pairs);
  endfunction

endpackage

// File: rtl/scr_trigger_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for asynchronous host control pins; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/scr_trigger_pulse_gen.sv
// Alternating forward/negative SCR trigger pulse generator with burst control and detector forbid.
// All outputs registered; start-pin edge to first forward pulse is four clock edges.
module scr_trigger_pulse_gen
  import scr_trigger_pulse_gen_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [PAIR_W-1:0] i_pairs,
  output logic              o_pulse_forward,
  output logic              o_pulse_negative,
  output logic              o_signal_forbid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_abort
);

  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic start_sync;
  logic stop_sync;

  sync_2ff u_sync_start (
    .clk_i  (i_clk_50m),
    .rst_ni (i_rst_n),
    .d_i    (i_start),
    .q_o    (start_sync)
  );

  sync_2ff u_sync_stop (
    .clk_i  (i_clk_50m),
    .rst_ni (i_rst_n),
    .d_i    (i_stop),
    .q_o    (stop_sync)
  );

  // Registered edge detect: this stage is what sets the four-edge start latency.
  logic start_prev_q;
  logic start_edge_q;

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      start_prev_q <= start_sync;
      start_edge_q <= start_sync & ~start_prev_q;
    end
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [PAIR_W-1:0] pairs_q;
  logic [PAIR_W-1:0] pair_cnt_q;
  logic [PAIR_W-1:0] pair_cnt_d;
  logic              fwd_q;
  logic              neg_q;
  logic              forbid_q;
  logic              busy_q;
  logic              done_q;
  logic              abort_q;

  assign cnt_d      = cnt_q + CNT_ONE;
  assign pair_cnt_d = pair_cnt_q + PAIR_W'(1);

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pairs_q    <= '0;
      pair_cnt_q <= '0;
      fwd_q      <= 1'b0;
      neg_q      <= 1'b0;
      forbid_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      // Stop wins over everything, including a done on the same cycle.
      if ((state_q != ST_IDLE) && stop_sync) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        fwd_q    <= 1'b0;
        neg_q    <= 1'b0;
        forbid_q <= 1'b1;
        busy_q   <= 1'b0;
        abort_q  <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_edge_q && !stop_sync) begin
              state_q    <= ST_FWD_ON;
              pairs_q    <= i_pairs;
              pair_cnt_q <= '0;
              cnt_q      <= '0;
              fwd_q      <= 1'b1;
              forbid_q   <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          ST_FWD_ON: begin
            cnt_q <= cnt_d;
            if (cnt_q == PW_LAST) begin
              fwd_q   <= 1'b0;
              state_q <= ST_FWD_OFF;
            end
          end
          ST_FWD_OFF: begin
            if (cnt_q == HP_LAST) begin
              cnt_q   <= '0;
              neg_q   <= 1'b1;
              state_q <= ST_NEG_ON;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          ST_NEG_ON: begin
            cnt_q <= cnt_d;
            if (cnt_q == PW_LAST) begin
              neg_q   <= 1'b0;
              state_q <= ST_NEG_OFF;
            end
          end
          ST_NEG_OFF: begin
            if (cnt_q == HP_LAST) begin
              cnt_q      <= '0;
              pair_cnt_q <= pair_cnt_d;
              if (burst_complete(pairs_q, pair_cnt_d)) begin
                state_q  <= ST_IDLE;
                done_q   <= 1'b1;
                forbid_q <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                state_q <= ST_FWD_ON;
                fwd_q   <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            fwd_q    <= 1'b0;
            neg_q    <= 1'b0;
            forbid_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_pulse_forward  = fwd_q;
  assign o_pulse_negative = neg_q;
  assign o_signal_forbid  = forbid_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_abort          = abort_q;

endmodule

// File: tb/tb_scr_trigger_pulse_gen.sv
// Scoreboard bench: stimulus queues timestamped output edges, a forked monitor matches them as they appear.
module tb_scr_trigger_pulse_gen;

  localparam int PW = 4;
  localparam int HP = 10;

  localparam int K_FR = 0;
  localparam int K_FF = 1;
  localparam int K_NR = 2;
  localparam int K_NF = 3;
  localparam int K_DN = 4;
  localparam int K_AB = 5;
  localparam int K_BR = 6;
  localparam int K_BF = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] pairs = 8'd0;
  logic       fwd, neg, forbid, busy, done, abort_s;

  scr_trigger_pulse_gen #(
    .PULSE_WIDTH (PW),
    .HALF_PERIOD (HP),
    .CNT_W       (8)
  ) dut (
    .i_clk_50m        (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_stop           (stop),
    .i_pairs          (pairs),
    .o_pulse_forward  (fwd),
    .o_pulse_negative (neg),
    .o_signal_forbid  (forbid),
    .o_busy           (busy),
    .o_done           (done),
    .o_abort          (abort_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic string kname(input int k);
    case (k)
      K_FR:    return "fwd_rise";
      K_FF:    return "fwd_fall";
      K_NR:    return "neg_rise";
      K_NF:    return "neg_fall";
      K_DN:    return "done";
      K_AB:    return "abort";
      K_BR:    return "busy_rise";
      K_BF:    return "busy_fall";
      default: return "none";
    endcase
  endfunction

  task automatic expect_ev(input int k, input int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic expect_pair(input int t, input bit first);
    expect_ev(K_FR, t);
    if (first) expect_ev(K_BR, t);
    expect_ev(K_FF, t + PW);
    expect_ev(K_NR, t + HP);
    expect_ev(K_NF, t + HP + PW);
  endtask

  task automatic observe(input int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s@%0d, required nothing", kname(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc) begin
        errors++;
        $display("FAIL event: got %s@%0d, required %s@%0d", kname(k), cyc, kname(e.kind), e.at);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic start_burst(input logic [7:0] p, output int t0);
    @(negedge clk);
    pairs = p;
    start = 1'b1;
    t0 = cyc + 4;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int t0;
    int npairs;
    #1 rst_n = 1'b0;

    fork
      begin
        logic pf = 1'b0, pn = 1'b0, pb = 1'b0;
        forever begin
          @(negedge clk);
          if (fwd && !pf) observe(K_FR);
          if (!fwd && pf) observe(K_FF);
          if (neg && !pn) observe(K_NR);
          if (!neg && pn) observe(K_NF);
          if (done) observe(K_DN);
          if (abort_s) observe(K_AB);
          if (busy && !pb) observe(K_BR);
          if (!busy && pb) observe(K_BF);
          pf = fwd;
          pn = neg;
          pb = busy;
          checks++;
          if ((fwd && neg) || (forbid && (fwd || neg)) || (forbid == busy)) begin
            errors++;
            $display("FAIL invariant@%0d: fwd=%b neg=%b forbid=%b busy=%b", cyc, fwd, neg, forbid, busy);
          end
        end
      end
    join_none

    // Reset values, held and after release
    repeat (3) @(negedge clk);
    check("reset_hold", {26'd0, forbid, busy, fwd, neg, done, abort_s}, 32'h20);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("reset_release", {26'd0, forbid, busy, fwd, neg, done, abort_s}, 32'h20);

    // Two-pair burst
    start_burst(8'd2, t0);
    expect_pair(t0, 1'b1);
    expect_pair(t0 + 2 * HP, 1'b0);
    expect_ev(K_DN, t0 + 4 * HP);
    expect_ev(K_BF, t0 + 4 * HP);
    wait_drain("two_pair", 80);
    check("two_pair_idle", {26'd0, forbid, busy, fwd, neg, done, abort_s}, 32'h20);

    // Continuous run past the 8-bit pair counter wrap, stopped mid negative pulse
    npairs = 260;
    start_burst(8'd0, t0);
    for (int k = 0; k < npairs; k++) expect_pair(t0 + 2 * HP * k, k == 0);
    expect_ev(K_FR, t0 + 2 * HP * npairs);
    expect_ev(K_FF, t0 + 2 * HP * npairs + PW);
    expect_ev(K_NR, t0 + 2 * HP * npairs + HP);
    expect_ev(K_NF, t0 + 2 * HP * npairs + HP + 3);
    expect_ev(K_AB, t0 + 2 * HP * npairs + HP + 3);
    expect_ev(K_BF, t0 + 2 * HP * npairs + HP + 3);
    while (cyc < t0 + 2 * HP * npairs + HP) @(negedge clk);
    stop = 1'b1;
    wait_drain("continuous_stop", 40);
    check("stop_forbid", {31'd0, forbid}, 32'h1);
    stop = 1'b0;
    repeat (4) @(negedge clk);

    // Restart edge while busy is ignored
    start_burst(8'd1, t0);
    expect_pair(t0, 1'b1);
    expect_ev(K_DN, t0 + 2 * HP);
    expect_ev(K_BF, t0 + 2 * HP);
    while (cyc < t0 + 5) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_drain("restart_ignored", 60);

    // Start edge with stop held: nothing happens
    stop = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("stop_held_idle", {26'd0, forbid, busy, fwd, neg, done, abort_s}, 32'h20);
    stop = 1'b0;
    repeat (4) @(negedge clk);

    // Async reset in the middle of the forward pulse
    start_burst(8'd1, t0);
    expect_ev(K_FR, t0);
    expect_ev(K_BR, t0);
    expect_ev(K_FF, t0 + 2);
    expect_ev(K_BF, t0 + 2);
    while (cyc < t0 + 1) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", {28'd0, forbid, busy, fwd, neg}, 32'h8);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("async_reset", 10);

    // Fresh burst after reset keeps the four-edge latency
    start_burst(8'd1, t0);
    expect_pair(t0, 1'b1);
    expect_ev(K_DN, t0 + 2 * HP);
    expect_ev(K_BF, t0 + 2 * HP);
    wait_drain("post_reset_burst", 60);
    check("final_idle", {26'd0, forbid, busy, fwd, neg, done, abort_s}, 32'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
